// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard signal bundle between datapath and hazard controller
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs_d;
    logic [4:0]       rt_d;
    logic [4:0]       rs_e;
    logic [4:0]       rt_e;
    logic [4:0]       writereg_e;
    logic [4:0]       writereg_m;
    logic [4:0]       writereg_w;
    logic             regwrite_e;
    logic             regwrite_m;
    logic             regwrite_w;
    logic [1:0]       memtoreg_e;
    logic [1:0]       memtoreg_m;
    logic             branch_d;
    logic             pcsrc_d;
    logic             dmem_req_m;
    logic             dmem_ready;

    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             stall_m;
    logic             flush_d;
    logic             flush_e;
    logic             flush_w;
    logic             forward_ad;
    logic             forward_bd;
    logic [1:0]       forward_ae;
    logic [1:0]       forward_be;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    // Pipeline datapath side: drives instruction state, receives controls.
    modport master (
        output rs_d, rt_d, rs_e, rt_e,
        output writereg_e, writereg_m, writereg_w,
        output regwrite_e, regwrite_m, regwrite_w,
        output memtoreg_e, memtoreg_m,
        output branch_d, pcsrc_d, dmem_req_m, dmem_ready,
        input  stall_f, stall_d, stall_e, stall_m,
        input  flush_d, flush_e, flush_w,
        input  forward_ad, forward_bd, forward_ae, forward_be,
        input  mem_timeout, stall_cycles
    );

    // Hazard controller side.
    modport slave (
        input  rs_d, rt_d, rs_e, rt_e,
        input  writereg_e, writereg_m, writereg_w,
        input  regwrite_e, regwrite_m, regwrite_w,
        input  memtoreg_e, memtoreg_m,
        input  branch_d, pcsrc_d, dmem_req_m, dmem_ready,
        output stall_f, stall_d, stall_e, stall_m,
        output flush_d, flush_e, flush_w,
        output forward_ad, forward_bd, forward_ae, forward_be,
        output mem_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard controller with memory-wait FSM and stall counter
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    hazard_ctrl_if.slave hz
);

    localparam int WC_W = $clog2(TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [1:0] MTR_LOAD = 2'b01;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MEMWAIT = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    state_t            state;
    logic [WC_W-1:0]   wait_cnt;
    logic              mem_timeout_q;
    logic [CNT_W-1:0]  stall_cycles_q;

    logic              memstall;
    logic              lwstall;
    logic              brstall;
    logic              e_hits_d;
    logic              m_load_hits_d;

    logic              stall_f_c;
    logic              stall_d_c;
    logic              stall_e_c;
    logic              stall_m_c;
    logic              flush_d_c;
    logic              flush_e_c;
    logic              flush_w_c;
    logic              forward_ad_c;
    logic              forward_bd_c;
    logic [1:0]        forward_ae_c;
    logic [1:0]        forward_be_c;

    // E-stage operand select: the younger M result wins over W; register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       rw_m,
        input logic [4:0] wr_m,
        input logic       rw_w,
        input logic [4:0] wr_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != 5'd0) begin
            if (rw_m && (wr_m == src)) begin
                sel = 2'b10;
            end else if (rw_w && (wr_w == src)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    always_comb begin
        memstall = 1'b0;
        case (state)
            S_RUN:     memstall = hz.dmem_req_m & ~hz.dmem_ready;
            S_MEMWAIT: memstall = ~hz.dmem_ready;
            S_HALT:    memstall = 1'b1;
            default:   memstall = 1'b0;
        endcase
    end

    assign lwstall = (hz.memtoreg_e == MTR_LOAD) && (hz.rt_e != 5'd0) &&
                     ((hz.rt_e == hz.rs_d) || (hz.rt_e == hz.rt_d));

    assign e_hits_d = hz.regwrite_e && (hz.writereg_e != 5'd0) &&
                      ((hz.writereg_e == hz.rs_d) || (hz.writereg_e == hz.rt_d));

    assign m_load_hits_d = (hz.memtoreg_m == MTR_LOAD) && (hz.writereg_m != 5'd0) &&
                           ((hz.writereg_m == hz.rs_d) || (hz.writereg_m == hz.rt_d));

    assign brstall = hz.branch_d && (e_hits_d || m_load_hits_d);

    // Every control is forced low while reset is asserted, independent of the clock.
    always_comb begin
        stall_f_c    = 1'b0;
        stall_d_c    = 1'b0;
        stall_e_c    = 1'b0;
        stall_m_c    = 1'b0;
        flush_d_c    = 1'b0;
        flush_e_c    = 1'b0;
        flush_w_c    = 1'b0;
        forward_ad_c = 1'b0;
        forward_bd_c = 1'b0;
        forward_ae_c = 2'b00;
        forward_be_c = 2'b00;
        if (reset_n) begin
            forward_ae_c = fwd_sel(hz.rs_e, hz.regwrite_m, hz.writereg_m,
                                   hz.regwrite_w, hz.writereg_w);
            forward_be_c = fwd_sel(hz.rt_e, hz.regwrite_m, hz.writereg_m,
                                   hz.regwrite_w, hz.writereg_w);
            forward_ad_c = hz.regwrite_m && (hz.writereg_m == hz.rs_d) && (hz.rs_d != 5'd0);
            forward_bd_c = hz.regwrite_m && (hz.writereg_m == hz.rt_d) && (hz.rt_d != 5'd0);
            if (memstall) begin
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                stall_e_c = 1'b1;
                stall_m_c = 1'b1;
                flush_w_c = 1'b1;
            end else if (lwstall || brstall) begin
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                flush_e_c = 1'b1;
            end else if (hz.pcsrc_d) begin
                flush_d_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_RUN;
            wait_cnt       <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (hz.dmem_req_m && !hz.dmem_ready) begin
                        state    <= S_MEMWAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                S_MEMWAIT: begin
                    if (hz.dmem_ready) begin
                        state    <= S_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state         <= S_HALT;
                        mem_timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state    <= S_RUN;
                    wait_cnt <= '0;
                end
            endcase

            // Saturates rather than wraps so a long HALT never reads back as a small count.
            if (stall_f_c && (stall_cycles_q != {CNT_W{1'b1}})) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
        end
    end

    assign hz.stall_f      = stall_f_c;
    assign hz.stall_d      = stall_d_c;
    assign hz.stall_e      = stall_e_c;
    assign hz.stall_m      = stall_m_c;
    assign hz.flush_d      = flush_d_c;
    assign hz.flush_e      = flush_e_c;
    assign hz.flush_w      = flush_w_c;
    assign hz.forward_ad   = forward_ad_c;
    assign hz.forward_bd   = forward_bd_c;
    assign hz.forward_ae   = forward_ae_c;
    assign hz.forward_be   = forward_be_c;
    assign hz.mem_timeout  = mem_timeout_q;
    assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int TIMEOUT = 5;
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hif.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: consecutive unready memory cycles, halt flag, stall tally.
    bit m_halt;
    bit m_tmo;
    int m_unready;
    int m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int fwd_e(input logic [4:0] src);
        if (src == 0) return 0;
        if (hif.regwrite_m && hif.writereg_m == src) return 2;
        if (hif.regwrite_w && hif.writereg_w == src) return 1;
        return 0;
    endfunction

    function automatic bit reads(input logic [4:0] r);
        return (r != 0) && (r == hif.rs_d || r == hif.rt_d);
    endfunction

    task automatic model_reset();
        m_halt = 0; m_tmo = 0; m_unready = 0; m_cnt = 0;
    endtask

    task automatic idle();
        hif.rs_d = 0; hif.rt_d = 0; hif.rs_e = 0; hif.rt_e = 0;
        hif.writereg_e = 0; hif.writereg_m = 0; hif.writereg_w = 0;
        hif.regwrite_e = 0; hif.regwrite_m = 0; hif.regwrite_w = 0;
        hif.memtoreg_e = 0; hif.memtoreg_m = 0;
        hif.branch_d = 0; hif.pcsrc_d = 0; hif.dmem_req_m = 0; hif.dmem_ready = 1;
    endtask

    task automatic randomize_inputs();
        hif.rs_d = 5'($urandom_range(0, 7)); hif.rt_d = 5'($urandom_range(0, 7));
        hif.rs_e = 5'($urandom_range(0, 7)); hif.rt_e = 5'($urandom_range(0, 7));
        hif.writereg_e = 5'($urandom_range(0, 7));
        hif.writereg_m = 5'($urandom_range(0, 7));
        hif.writereg_w = 5'($urandom_range(0, 7));
        hif.regwrite_e = 1'($urandom); hif.regwrite_m = 1'($urandom);
        hif.regwrite_w = 1'($urandom);
        hif.memtoreg_e = 2'($urandom); hif.memtoreg_m = 2'($urandom);
        hif.branch_d = 1'($urandom); hif.pcsrc_d = 1'($urandom);
        hif.dmem_req_m = ($urandom_range(0, 9) < 4);
        hif.dmem_ready = ($urandom_range(0, 9) < 5);
    endtask

    // Compare every output against the model, then advance the model past the coming edge.
    task automatic check_cycle();
        bit mem, hzd, hold_f;
        if (m_halt) mem = 1;
        else if (m_unready > 0) mem = !hif.dmem_ready;
        else mem = hif.dmem_req_m && !hif.dmem_ready;
        hzd = !mem && ((hif.memtoreg_e == 2'b01 && reads(hif.rt_e)) ||
              (hif.branch_d && ((hif.regwrite_e && reads(hif.writereg_e)) ||
                                (hif.memtoreg_m == 2'b01 && reads(hif.writereg_m)))));
        hold_f = mem || hzd;
        check("stall_f", 32'(hif.stall_f), 32'(hold_f));
        check("stall_d", 32'(hif.stall_d), 32'(hold_f));
        check("stall_e", 32'(hif.stall_e), 32'(mem));
        check("stall_m", 32'(hif.stall_m), 32'(mem));
        check("flush_w", 32'(hif.flush_w), 32'(mem));
        check("flush_e", 32'(hif.flush_e), 32'(hzd));
        check("flush_d", 32'(hif.flush_d), 32'(!hold_f && hif.pcsrc_d));
        check("fwd_ae", 32'(hif.forward_ae), 32'(fwd_e(hif.rs_e)));
        check("fwd_be", 32'(hif.forward_be), 32'(fwd_e(hif.rt_e)));
        check("fwd_ad", 32'(hif.forward_ad),
              32'(hif.rs_d != 0 && hif.regwrite_m && hif.writereg_m == hif.rs_d));
        check("fwd_bd", 32'(hif.forward_bd),
              32'(hif.rt_d != 0 && hif.regwrite_m && hif.writereg_m == hif.rt_d));
        check("mem_timeout", 32'(hif.mem_timeout), 32'(m_tmo));
        check("stall_cycles", 32'(hif.stall_cycles), 32'(m_cnt));
        if (hold_f && m_cnt < CNT_MAX) m_cnt++;
        if (!m_halt) begin
            if (mem) begin
                m_unready++;
                if (m_unready == TIMEOUT) begin
                    m_halt = 1;
                    m_tmo = 1;
                end
            end else begin
                m_unready = 0;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stalls"}, 32'({hif.stall_f, hif.stall_d, hif.stall_e, hif.stall_m}), 0);
        check({tag, "_flush"}, 32'({hif.flush_d, hif.flush_e, hif.flush_w}), 0);
        check({tag, "_fwd"}, 32'({hif.forward_ad, hif.forward_bd, hif.forward_ae, hif.forward_be}), 0);
        check({tag, "_tmo"}, 32'(hif.mem_timeout), 0);
        check({tag, "_cnt"}, 32'(hif.stall_cycles), 0);
    endtask

    task automatic settle();
        #3;
        check_cycle();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1: asserts reset mid-cycle, holds it across an edge, releases it.
    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        idle();
        model_reset();
        hif.dmem_req_m = 1; hif.dmem_ready = 0; hif.rs_e = 3; hif.regwrite_m = 1;
        hif.writereg_m = 3;
        #2;
        check_zero("rst_init");
        @(posedge clk);
        #1;
        check_zero("rst_edge");
        reset_n = 1'b1;
        idle();

        // Load-use: lw $2 in E, consumer in D, then forwarded from M.
        hif.memtoreg_e = 2'b01; hif.rt_e = 2; hif.regwrite_e = 1; hif.writereg_e = 2;
        hif.rs_d = 2; hif.rt_d = 7;
        settle();
        check("lw_stall_f", 32'(hif.stall_f), 1);
        check("lw_flush_e", 32'(hif.flush_e), 1);
        advance();
        idle();
        hif.memtoreg_m = 2'b01; hif.regwrite_m = 1; hif.writereg_m = 2; hif.rs_e = 2;
        settle();
        check("lw_fwd_ae", 32'(hif.forward_ae), 2);
        check("lw_no_stall", 32'(hif.stall_f), 0);
        advance();

        // M beats W; register 0 is never forwarded.
        idle();
        hif.regwrite_m = 1; hif.writereg_m = 3; hif.regwrite_w = 1; hif.writereg_w = 3;
        hif.rs_e = 3; hif.rt_e = 3;
        settle();
        check("mw_prio_ae", 32'(hif.forward_ae), 2);
        advance();
        hif.writereg_m = 0; hif.writereg_w = 0; hif.rs_e = 0; hif.rt_e = 0;
        settle();
        check("zero_reg_ae", 32'(hif.forward_ae), 0);
        advance();

        // Branch depending on E result stalls, then forwards from M.
        idle();
        hif.branch_d = 1; hif.rs_d = 4; hif.regwrite_e = 1; hif.writereg_e = 4; hif.pcsrc_d = 1;
        settle();
        check("br_stall_f", 32'(hif.stall_f), 1);
        check("br_no_flush_d", 32'(hif.flush_d), 0);
        advance();
        idle();
        hif.branch_d = 1; hif.rs_d = 4; hif.regwrite_m = 1; hif.writereg_m = 4; hif.pcsrc_d = 1;
        settle();
        check("br_fwd_ad", 32'(hif.forward_ad), 1);
        check("br_flush_d", 32'(hif.flush_d), 1);
        advance();

        // Three-cycle memory wait overlapping a load-use hazard.
        idle();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            hif.dmem_req_m = 1; hif.dmem_ready = 0;
            hif.memtoreg_e = 2'b01; hif.rt_e = 5; hif.rs_d = 5;
            settle();
            check("mw_stall_m", 32'(hif.stall_m), 1);
            check("mw_flush_e", 32'(hif.flush_e), 0);
            advance();
        end
        idle();
        hif.dmem_req_m = 1; hif.dmem_ready = 1;
        settle();
        check("mw_release", 32'(hif.stall_f), 0);
        advance();
        idle();
        settle();
        check("mw_count3", 32'(hif.stall_cycles), 3);
        advance();

        // Timeout into HALT; only reset gets out.
        for (int i = 0; i < TIMEOUT; i++) begin
            idle();
            hif.dmem_req_m = 1; hif.dmem_ready = 0;
            settle();
            advance();
        end
        idle();
        settle();
        check("halt_timeout", 32'(hif.mem_timeout), 1);
        check("halt_stall_e", 32'(hif.stall_e), 1);
        advance();
        do_reset();
        idle();
        settle();
        advance();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                randomize_inputs();
                settle();
                advance();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
